// File: rtl/bin_to_bcd_display_pkg.sv
// bin_to_bcd_display_pkg: display codes, FSM states and BCD sizing shared by the converter
package bin_to_bcd_display_pkg;
  localparam logic [7:0] DISP_BLANK = 8'h0A;
  localparam logic [7:0] DISP_L     = 8'h0B;
  localparam logic [7:0] DISP_P     = 8'h0C;
  localparam logic [7:0] DISP_E     = 8'h0D;
  localparam logic [7:0] DISP_S     = 8'h0E;
  localparam logic [7:0] DISP_F     = 8'h0F;
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, FMT = 2'd2} state_t;
  // Enough nibbles for every digit plus an overflow nibble, and for the full input range.
  function automatic int bcd_nibbles(input int w, input int d);
    int n;
    n = (w * 100 + 331) / 332;
    return (n > d + 1) ? n : d + 1;
  endfunction
endpackage

// File: rtl/bin_to_bcd_display_dd_add3.sv
// dd_add3: double-dabble correction, adds 3 to a BCD nibble that is 5 or more
module dd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  always_comb adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: iterative double-dabble converter producing blanked 7-segment digit codes
module bin_to_bcd_display
  import bin_to_bcd_display_pkg::*;
#(
  parameter int IN_WIDTH   = 20,
  parameter int NUM_DIGITS = 6,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     value,
  output logic                    ready,
  output logic                    done,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] disp_codes
);
  localparam int BCD_N = bcd_nibbles(IN_WIDTH, NUM_DIGITS);
  localparam int BCD_W = 4 * BCD_N;
  localparam int CW    = $clog2(IN_WIDTH + 1);
  state_t                  state, state_n;
  logic [IN_WIDTH-1:0]     shift_reg;
  logic [BCD_W-1:0]        bcd_reg, bcd_adj, bcd_next;
  logic [CW-1:0]           cnt;
  logic                    last, ovf_fmt;
  logic [NUM_DIGITS:1]     seen;
  logic [8*NUM_DIGITS-1:0] codes_fmt;
  for (genvar g = 0; g < BCD_N; g++) begin : g_add3
    dd_add3 u_add3 (.nib(bcd_reg[4*g+:4]), .adj(bcd_adj[4*g+:4]));
  end
  assign bcd_next = BCD_W'({bcd_adj, shift_reg[IN_WIDTH-1]});
  assign ready    = (state == IDLE);
  assign last     = (state == CONV) && (cnt == CW'(1));
  // Formatting looks at the post-shift value so the codes land together with done.
  assign ovf_fmt  = |bcd_next[BCD_W-1:4*NUM_DIGITS];
  assign seen[NUM_DIGITS] = 1'b0;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_fmt
    if (d == 0) begin : g_lsd
      assign codes_fmt[7:0] = ovf_fmt ? DISP_E : {4'h0, bcd_next[3:0]};
    end else begin : g_upper
      assign seen[d] = seen[d+1] | (|bcd_next[4*d+:4]);
      assign codes_fmt[8*d+:8] = ovf_fmt ? DISP_BLANK :
                                 (BLANK_LZ != 0 && !seen[d]) ? DISP_BLANK :
                                 {4'h0, bcd_next[4*d+:4]};
    end
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? CONV :
              last                     ? FMT  :
              (state == FMT)           ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bcd_reg    <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      disp_codes <= {NUM_DIGITS{DISP_BLANK}};
    end else begin
      state <= state_n;
      done  <= last;
      if (state == IDLE && start) begin
        shift_reg <= value;
        bcd_reg   <= '0;
        cnt       <= CW'(IN_WIDTH);
      end else if (state == CONV) begin
        shift_reg <= shift_reg << 1;
        bcd_reg   <= bcd_next;
        cnt       <= cnt - CW'(1);
      end
      if (last) begin
        disp_codes <= codes_fmt;
        overflow   <= ovf_fmt;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb_bin_to_bcd_display: randomized and directed checks against a decimal-arithmetic display model
module tb_bin_to_bcd_display;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [19:0] value0 = '0, value1 = '0;
  logic        ready0, done0, ovf0, ready1, done1, ovf1;
  logic [47:0] codes0, codes1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_display u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .value(value0),
    .ready(ready0), .done(done0), .overflow(ovf0), .disp_codes(codes0)
  );
  bin_to_bcd_display #(.IN_WIDTH(20), .NUM_DIGITS(6), .BLANK_LZ(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .value(value1),
    .ready(ready1), .done(done1), .overflow(ovf1), .disp_codes(codes1)
  );

  function automatic logic [47:0] model(input int unsigned v, input bit blank);
    int unsigned t;
    int nd;
    logic [47:0] r;
    if (v > 999999) return {{5{8'h0A}}, 8'h0D};
    nd = 1;
    t = v;
    while (t >= 10) begin t = t / 10; nd++; end
    t = v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[8*i+:8] = (blank && i >= nd) ? 8'h0A : 8'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic convert(input bit sel, input logic [19:0] v, output int lat, output int low,
                         output logic [47:0] codes, output logic ovf);
    @(negedge clk);
    if (sel) begin value1 = v; start1 = 1'b1; end
    else begin value0 = v; start0 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    lat = -1;
    low = 0;
    codes = 'x;
    ovf = 1'bx;
    for (int n = 0; n < 40; n++) begin
      if (sel ? ready1 : ready0) break;
      low++;
      if ((sel ? done1 : done0) && lat < 0) begin
        lat = n;
        codes = sel ? codes1 : codes0;
        ovf = sel ? ovf1 : ovf0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ready0, done0, ovf0} !== 3'b100 || codes0 !== 48'h0A0A0A0A0A0A) begin
      bad++;
      $display("FAIL reset_held: rdy/done/ovf=%b codes=%h want 100 0a0a0a0a0a0a", {ready0, done0, ovf0}, codes0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ready0, done0, ovf0} !== 3'b100 || codes0 !== 48'h0A0A0A0A0A0A) begin
      bad++;
      $display("FAIL reset_released: rdy/done/ovf=%b codes=%h want 100 0a0a0a0a0a0a", {ready0, done0, ovf0}, codes0);
    end
  endtask

  task automatic test_directed;
    int lat, low;
    logic [47:0] c;
    logic o;
    convert(1'b0, 20'd0, lat, low, c, o);
    total++;
    if (lat !== 20 || c !== 48'h0A0A0A0A0A00 || o !== 1'b0) begin
      bad++;
      $display("FAIL zero: lat=%0d codes=%h ovf=%b want 20 0a0a0a0a0a00 0", lat, c, o);
    end
    convert(1'b0, 20'd987654, lat, low, c, o);
    total++;
    if (c !== 48'h090807060504 || o !== 1'b0) begin
      bad++;
      $display("FAIL big: codes=%h ovf=%b want 090807060504 0", c, o);
    end
    total++;
    if (low !== 21 || lat !== 20) begin
      bad++;
      $display("FAIL busy_len: ready_low=%0d done_at=%0d want 21 20", low, lat);
    end
    convert(1'b0, 20'd1000000, lat, low, c, o);
    total++;
    if (c !== 48'h0A0A0A0A0A0D || o !== 1'b1) begin
      bad++;
      $display("FAIL overflow: codes=%h ovf=%b want 0a0a0a0a0a0d 1", c, o);
    end
    convert(1'b0, 20'd42, lat, low, c, o);
    total++;
    if (c !== 48'h0A0A0A0A0402 || o !== 1'b0) begin
      bad++;
      $display("FAIL after_overflow: codes=%h ovf=%b want 0a0a0a0a0402 0", c, o);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (codes0 !== 48'h0A0A0A0A0402 || ovf0 !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL hold: codes=%h ovf=%b done=%b want 0a0a0a0a0402 0 0", codes0, ovf0, done0);
    end
    convert(1'b1, 20'd305, lat, low, c, o);
    total++;
    if (c !== 48'h000000030005 || o !== 1'b0 || lat !== 20) begin
      bad++;
      $display("FAIL no_blank: codes=%h ovf=%b lat=%0d want 000000030005 0 20", c, o, lat);
    end
  endtask

  task automatic test_reset_mid;
    int pulses, lat, accepts;
    logic [47:0] c;
    @(negedge clk);
    value0 = 20'd123456;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready0, done0, ovf0} !== 3'b100 || codes0 !== 48'h0A0A0A0A0A0A) begin
      bad++;
      $display("FAIL mid_reset: rdy/done/ovf=%b codes=%h want 100 0a0a0a0a0a0a", {ready0, done0, ovf0}, codes0);
    end
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done0) pulses++;
    end
    total++;
    if (pulses !== 0 || codes0 !== 48'h0A0A0A0A0A0A) begin
      bad++;
      $display("FAIL discarded: done_pulses=%0d codes=%h want 0 0a0a0a0a0a0a", pulses, codes0);
    end
    @(negedge clk);
    value0 = 20'd7;
    start0 = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    lat = -1;
    accepts = 0;
    c = 'x;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (done0) begin pulses++; lat = n; c = codes0; end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (!ready0) accepts++;
      if (done0) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (lat !== 20 || c !== 48'h0A0A0A0A0A07) begin
      bad++;
      $display("FAIL fresh_start: lat=%0d codes=%h want 20 0a0a0a0a0a07", lat, c);
    end
    total++;
    if (pulses !== 1 || accepts !== 0) begin
      bad++;
      $display("FAIL held_start: done_pulses=%0d busy_cycles_after=%0d want 1 0", pulses, accepts);
    end
  endtask

  task automatic test_random;
    int lat, low;
    logic [47:0] c;
    logic o;
    logic [19:0] v;
    for (int k = 0; k < 30; k++) begin
      case (k % 3)
        0: v = 20'($urandom_range(0, 1048575));
        1: v = 20'($urandom_range(0, 999));
        default: v = 20'($urandom_range(999990, 1000010));
      endcase
      convert(k[0], v, lat, low, c, o);
      total++;
      if (lat !== 20 || low !== 21 || c !== model(v, !k[0]) || o !== (v > 20'd999999)) begin
        bad++;
        $display("FAIL random dut%0d v=%0d: lat=%0d low=%0d codes=%h ovf=%b want 20 21 %h %b",
                 k[0], v, lat, low, c, o, model(v, !k[0]), v > 20'd999999);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
